mult_nin_pipe: RTL

- Parametrised, pipelined successor to the 3-input fixed-point multiplier.
- Multiplies NIN signed Q(DWIDTH-FRAC).FRAC operands, one multiply per pipeline stage.
- Each stage rescales by FRAC, with selectable rounding and saturation, and reports overflow.
- Sits in the sigmoid/neuron datapath behind a valid/ready handshake so upstream and downstream blocks can stall it.

---
 rtl/mult_nin_pipe_pkg.sv | 57 +++++
 rtl/mult_nin_pipe_stage.sv | 65 ++++++
 rtl/mult_nin_pipe.sv | 112 +++++++++++
 3 files changed

// File: rtl/mult_nin_pipe_pkg.sv
// ============================================================================
// Module : mult_nin_pipe_pkg
// Desc   : Shared fixed-point mode constants and rescale/saturate helpers.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mult_nin_pipe_pkg;

    // Wide enough for a full 2*DWIDTH product for any DWIDTH up to 64.
    localparam int FXP_W      = 128;

    localparam int RND_TRUNC  = 0;
    localparam int RND_HALFUP = 1;
    localparam int OVF_WRAP   = 0;
    localparam int OVF_SAT    = 1;

    typedef logic signed [FXP_W-1:0] fxp_wide_t;

    function automatic fxp_wide_t fxp_rescale(input fxp_wide_t p, input int frac, input int rnd);
        fxp_wide_t r;
        r = p;
        if (rnd == RND_HALFUP) begin
            r = r + (fxp_wide_t'(1) <<< (frac - 1));
        end
        return r >>> frac;
    endfunction

    function automatic logic fxp_ovf(input fxp_wide_t s, input int dwidth);
        fxp_wide_t hi;
        fxp_wide_t lo;
        hi = (fxp_wide_t'(1) <<< (dwidth - 1)) - fxp_wide_t'(1);
        lo = -hi - fxp_wide_t'(1);
        return (s > hi) || (s < lo);
    endfunction

    // Wrap mode returns the value untouched; the caller keeps the low bits.
    function automatic fxp_wide_t fxp_sat(input fxp_wide_t s, input int dwidth, input int mode);
        fxp_wide_t hi;
        fxp_wide_t lo;
        fxp_wide_t r;
        hi = (fxp_wide_t'(1) <<< (dwidth - 1)) - fxp_wide_t'(1);
        lo = -hi - fxp_wide_t'(1);
        r  = s;
        if (mode != OVF_WRAP) begin
            if (s > hi) begin
                r = hi;
            end else if (s < lo) begin
                r = lo;
            end
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mult_nin_pipe_stage.sv
// ============================================================================
// Module : fxp_mul_stage
// Desc   : One multiply/rescale/saturate pipeline stage with valid and ovf.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fxp_mul_stage
    import mult_nin_pipe_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int FRAC   = 24,
    parameter int ROUND  = RND_TRUNC,
    parameter int SAT    = OVF_SAT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              in_valid,
    input  logic [DWIDTH-1:0] in_acc,
    input  logic [DWIDTH-1:0] in_op,
    input  logic              in_ovf,
    output logic              out_valid,
    output logic [DWIDTH-1:0] out_acc,
    output logic              out_ovf
);

    logic signed [2*DWIDTH-1:0] prod;
    fxp_wide_t                  scaled;
    logic [DWIDTH-1:0]          acc_d, acc_q;
    logic                       ovf_d, ovf_q;
    logic                       valid_d, valid_q;

    always_comb begin
        prod    = (2*DWIDTH)'(signed'(in_acc)) * (2*DWIDTH)'(signed'(in_op));
        scaled  = fxp_rescale(fxp_wide_t'(prod), FRAC, ROUND);
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        valid_d = valid_q;
        if (en) begin
            valid_d = in_valid;
            acc_d   = DWIDTH'(fxp_sat(scaled, DWIDTH, SAT));
            ovf_d   = in_ovf | fxp_ovf(scaled, DWIDTH);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
        end
    end

    assign out_valid = valid_q;
    assign out_acc   = acc_q;
    assign out_ovf   = ovf_q;

endmodule

`default_nettype wire

// File: rtl/mult_nin_pipe.sv
// ============================================================================
// Module : mult_nin_pipe
// Desc   : NIN-operand signed fixed-point multiplier, one multiply per stage.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mult_nin_pipe
    import mult_nin_pipe_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int FRAC   = 24,
    parameter int NIN    = 3,
    parameter int ROUND  = RND_TRUNC,
    parameter int SAT    = OVF_SAT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [NIN*DWIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DWIDTH-1:0]     out_data,
    output logic                  out_ovf
);

    localparam int NST = NIN - 1;

    logic              adv;
    logic              stg_valid [NST];
    logic [DWIDTH-1:0] stg_acc   [NST];
    logic              stg_ovf   [NST];
    // Operand k as seen by the stage that consumes it (k-1 cycles late for k >= 2).
    logic [DWIDTH-1:0] op_dly    [NIN];

    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    assign op_dly[0] = in_data[0 +: DWIDTH];
    assign op_dly[1] = in_data[DWIDTH +: DWIDTH];

    generate
        for (genvar j = 2; j < NIN; j++) begin : g_skew
            logic [DWIDTH-1:0] line_d [j-1];
            logic [DWIDTH-1:0] line_q [j-1];

            always_comb begin
                line_d = line_q;
                if (adv) begin
                    line_d[0] = in_data[j*DWIDTH +: DWIDTH];
                    for (int k = 1; k < j - 1; k++) begin
                        line_d[k] = line_q[k-1];
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k < j - 1; k++) begin
                        line_q[k] <= '0;
                    end
                end else begin
                    line_q <= line_d;
                end
            end

            assign op_dly[j] = line_q[j-2];
        end

        for (genvar s = 0; s < NST; s++) begin : g_stage
            logic              valid_in;
            logic [DWIDTH-1:0] acc_in;
            logic              ovf_in;

            if (s == 0) begin : g_first
                assign valid_in = in_valid;
                assign acc_in   = op_dly[0];
                assign ovf_in   = 1'b0;
            end else begin : g_next
                assign valid_in = stg_valid[s-1];
                assign acc_in   = stg_acc[s-1];
                assign ovf_in   = stg_ovf[s-1];
            end

            fxp_mul_stage #(
                .DWIDTH (DWIDTH),
                .FRAC   (FRAC),
                .ROUND  (ROUND),
                .SAT    (SAT)
            ) u_stage (
                .clk       (clk),
                .rst_n     (rst_n),
                .en        (adv),
                .in_valid  (valid_in),
                .in_acc    (acc_in),
                .in_op     (op_dly[s+1]),
                .in_ovf    (ovf_in),
                .out_valid (stg_valid[s]),
                .out_acc   (stg_acc[s]),
                .out_ovf   (stg_ovf[s])
            );
        end
    endgenerate

    assign out_valid = stg_valid[NST-1];
    assign out_data  = stg_acc[NST-1];
    assign out_ovf   = stg_ovf[NST-1];

endmodule

`default_nettype wire
